// File: rtl/exec_unit.sv
// Execute/writeback stage: single-cycle ALU ops or a DW-step shift-add multiply, then one write-port pulse.
// Latency: WB one cycle after accept (non-MUL) or DW+1 cycles (MUL); start while busy is dropped, not queued.
module exec_unit #(
  parameter int DW  = 8,
  parameter int RAW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [RAW-1:0] rd,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  output logic           busy,
  output logic           done,
  output logic           we,
  output logic [RAW-1:0] wad,
  output logic [DW-1:0]  wd,
  output logic           zf,
  output logic           cf
);

  localparam int SW = $clog2(DW);
  localparam int CW = $clog2(DW + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;

  state_t         state_q, state_d;
  logic [RAW-1:0] rd_q, rd_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic [DW-1:0]  mcand_q, mcand_d;
  logic [DW-1:0]  mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RAW-1:0] wad_q, wad_d;
  logic [DW-1:0]  wd_q, wd_d;
  logic           zf_q, zf_d;
  logic           cf_q, cf_d;
  logic [DW:0]    alu;

  // Bit DW carries the ADD carry-out or, for SUB, the borrow (wraps when a < b).
  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu = {1'b0, a} - {1'b0, b};
      OP_AND:  alu = {1'b0, a & b};
      OP_OR:   alu = {1'b0, a | b};
      OP_XOR:  alu = {1'b0, a ^ b};
      OP_SHL:  alu = {1'b0, a << b[SW-1:0]};
      OP_MUL:  alu = '0;
      default: alu = {1'b0, b};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    wad_d    = wad_q;
    wd_d     = wd_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_d = rd;
          if (op == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = CW'(DW);
            state_d  = S_MUL;
          end else begin
            wad_d   = rd;
            wd_d    = alu[DW-1:0];
            zf_d    = (alu[DW-1:0] == '0);
            cf_d    = (op == OP_ADD || op == OP_SUB) ? alu[DW] : 1'b0;
            state_d = S_WB;
          end
        end
      end
      S_MUL: begin
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          wad_d   = rd_q;
          wd_d    = acc_d;
          zf_d    = (acc_d == '0);
          cf_d    = 1'b0;
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rd_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      wad_q    <= '0;
      wd_q     <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      wad_q    <= wad_d;
      wd_q     <= wd_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign we   = (state_q == S_WB);
  assign done = we;
  assign wad  = wad_q;
  assign wd   = wd_q;
  assign zf   = zf_q;
  assign cf   = cf_q;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [1:0] rd = 2'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       busy, done, we, zf, cf;
  logic [1:0] wad;
  logic [7:0] wd;

  int n_cmp = 0;
  int n_err = 0;

  exec_unit #(.DW(8), .RAW(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rd(rd), .a(a), .b(b),
    .busy(busy), .done(done), .we(we), .wad(wad), .wd(wd), .zf(zf), .cf(cf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns {carry, result} computed with plain integer arithmetic.
  function automatic logic [8:0] ref_op(input logic [2:0] o, input int x, input int y);
    int   r;
    logic c;
    c = 1'b0;
    case (o)
      3'd0: begin r = x + y; c = (r > 255); end
      3'd1: begin r = x - y; c = (x < y); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x << (y % 8);
      3'd6: r = x * y;
      default: r = y;
    endcase
    return {c, r[7:0]};
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [1:0] r,
                        input logic [7:0] x, input logic [7:0] y, input bit inject);
    logic [8:0] e;
    int cyc, lat, extra;
    e   = ref_op(o, int'(x), int'(y));
    lat = (o == 3'd6) ? 9 : 1;
    @(negedge clk);
    start = 1'b1; op = o; rd = r; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); rd = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
    cyc = 1;
    while (!we && cyc < 40) begin
      if (inject && cyc == 3) begin
        start = 1'b1; op = 3'd0; rd = r + 2'd1; a = 8'd1; b = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, lat);
    check("busy_wb", busy, 1);
    check("done", done, 1);
    check("wad", wad, r);
    check("wd", wd, e[7:0]);
    check("zf", zf, (e[7:0] == 8'd0));
    check("cf", cf, e[8]);
    if (inject) begin
      start = 1'b1; op = 3'd0; rd = r + 2'd1; a = 8'd1; b = 8'd1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("we_after", we, 0);
    check("busy_after", busy, 0);
    check("wd_hold", wd, e[7:0]);
    check("wad_hold", wad, r);
    check("cf_hold", cf, e[8]);
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (we) extra++;
    end
    check("no_extra_we", extra, 0);
  endtask

  task automatic reset_mid_mul();
    int extra;
    @(negedge clk);
    start = 1'b1; op = 3'd6; rd = 2'd2; a = 8'd7; b = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("busy_pre_rst", busy, 1);
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_we", we, 0);
    check("rst_done", done, 0);
    check("rst_wad", wad, 0);
    check("rst_wd", wd, 0);
    check("rst_flags", {zf, cf}, 0);
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (we || busy) extra++;
    end
    check("no_we_after_rst", extra, 0);
  endtask

  task automatic back_to_back();
    @(negedge clk);
    start = 1'b1; op = 3'd7; rd = 2'd1; a = 8'($urandom); b = 8'h5A;
    @(posedge clk); #1;
    check("b2b_we1", we, 1);
    check("b2b_wad1", wad, 1);
    check("b2b_wd1", wd, 8'h5A);
    op = 3'd5; rd = 2'd0; a = 8'd3; b = 8'd2;
    @(posedge clk); #1;
    check("b2b_gap", we, 0);
    @(posedge clk); #1;
    check("b2b_we2", we, 1);
    check("b2b_wad2", wad, 0);
    check("b2b_wd2", wd, 12);
    check("b2b_flags", {zf, cf}, 0);
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b_end", we, 0);
  endtask

  function automatic logic [7:0] pick();
    int s;
    s = $urandom_range(0, 5);
    if (s == 0) return 8'd0;
    if (s == 1) return 8'd255;
    return 8'($urandom);
  endfunction

  initial begin
    #1;
    check("reset_outs", {busy, done, we, zf, cf}, 0);
    check("reset_wad_wd", {wad, wd}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(3'd0, 2'd2, 8'd200, 8'd100, 1'b0);
    run_op(3'd1, 2'd1, 8'd5, 8'd5, 1'b0);
    run_op(3'd1, 2'd1, 8'd3, 8'd5, 1'b0);
    run_op(3'd6, 2'd3, 8'd13, 8'd11, 1'b0);
    run_op(3'd6, 2'd3, 8'd20, 8'd20, 1'b0);
    run_op(3'd6, 2'd3, 8'd13, 8'd11, 1'b1);
    reset_mid_mul();
    run_op(3'd0, 2'd1, 8'd1, 8'd2, 1'b0);
    back_to_back();

    for (int i = 0; i < 150; i++) begin
      run_op(3'($urandom), 2'($urandom), pick(), pick(), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
